// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - sequencer for one matrix-multiply pass of a systolic array
//
// Purpose: accepts a start command with inner dimension k_len, gates k_len host
// wavefronts into the row/col FIFOs, issues diagonally skewed FIFO read enables,
// waits for the array to drain and then pulses done.
//
// Optional feature: define SA_CTRL_ABORT_EN to add the abort input (pass abort
// with a one-cycle err pulse). Default build has no abort port.
//
// Ports:
//   clk        in   1     clock, rising edge
//   rstn       in   1     asynchronous active-low reset
//   start      in   1     command strobe, sampled only in IDLE
//   abort      in   1     (SA_CTRL_ABORT_EN only) abandon the current pass
//   k_len      in   KW    inner dimension, sampled with start
//   load_valid in   1     host presents one row+col wavefront
//   load_ready out  1     controller accepts wavefront this cycle
//   row_w_en   out  ROWS  row FIFO write enables
//   col_w_en   out  COLS  col FIFO write enables
//   row_r_en   out  ROWS  row FIFO read enables, row i delayed i cycles
//   col_r_en   out  COLS  col FIFO read enables, col j delayed j cycles
//   pe_clr     out  1     accumulator clear, in the accepted start cycle
//   busy       out  1     high in LOAD/STREAM/DRAIN
//   done       out  1     one-cycle pulse, results valid
//   err        out  1     one-cycle pulse, illegal k_len (or abort)

module systolic_array_ctrl #(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int DEPTH     = 8,
  parameter int KW        = 4,
  parameter int DRAIN_CYC = ROWS + COLS - 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
`ifdef SA_CTRL_ABORT_EN
  input  logic            abort,
`endif
  input  logic [KW-1:0]   k_len,
  input  logic            load_valid,
  output logic            load_ready,
  output logic [ROWS-1:0] row_w_en,
  output logic [COLS-1:0] col_w_en,
  output logic [ROWS-1:0] row_r_en,
  output logic [COLS-1:0] col_r_en,
  output logic            pe_clr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int MAXRC      = (ROWS > COLS) ? ROWS : COLS;
  localparam int STREAM_MAX = DEPTH + MAXRC - 1;
  localparam int CNT_MAX    = (STREAM_MAX > DRAIN_CYC) ? STREAM_MAX : DRAIN_CYC;
  localparam int CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;        // beat count in LOAD, t in STREAM, wait count in DRAIN
  logic [KW-1:0] k_q;
  logic          load_ready_q;

  logic [CW-1:0] k_ext;
  logic [CW-1:0] stream_last;
  logic          k_ok;
  logic          busy_st;
  logic          beat;
  logic          abort_err;

  assign k_ext       = CW'(k_q);
  // STREAM covers t = 0 .. k_len + MAXRC - 2
  assign stream_last = k_ext + CW'(MAXRC - 2);
  assign k_ok        = (k_len != '0) && (k_len <= KW'(DEPTH));
  assign busy_st     = (state_q == ST_LOAD) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign beat        = load_valid && load_ready_q;

`ifdef SA_CTRL_ABORT_EN
  logic abort_err_q;
  assign abort_err = abort_err_q;
`else
  assign abort_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      load_ready_q <= 1'b0;
`ifdef SA_CTRL_ABORT_EN
      abort_err_q  <= 1'b0;
`endif
    end else begin
`ifdef SA_CTRL_ABORT_EN
      abort_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start && k_ok) begin
            k_q          <= k_len;
            cnt_q        <= '0;
            load_ready_q <= 1'b1;
            state_q      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            if (cnt_q == k_ext - CW'(1)) begin
              load_ready_q <= 1'b0;
              cnt_q        <= '0;
              state_q      <= ST_STREAM;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_STREAM: begin
          if (cnt_q == stream_last) begin
            cnt_q   <= '0;
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == CW'(DRAIN_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
`ifdef SA_CTRL_ABORT_EN
      // Abort overrides whatever the case above decided for this cycle.
      if (abort && busy_st) begin
        state_q      <= ST_IDLE;
        cnt_q        <= '0;
        load_ready_q <= 1'b0;
        abort_err_q  <= 1'b1;
      end
`endif
    end
  end

  // Diagonal skew: lane i reads during t in [i, i + k_len).
  always_comb begin
    row_r_en = '0;
    col_r_en = '0;
    if (state_q == ST_STREAM) begin
      for (int i = 0; i < ROWS; i++) begin
        row_r_en[i] = ({1'b0, cnt_q} >= (CW+1)'(i)) &&
                      ({1'b0, cnt_q} <  (CW+1)'(i) + {1'b0, k_ext});
      end
      for (int j = 0; j < COLS; j++) begin
        col_r_en[j] = ({1'b0, cnt_q} >= (CW+1)'(j)) &&
                      ({1'b0, cnt_q} <  (CW+1)'(j) + {1'b0, k_ext});
      end
    end
  end

  assign load_ready = load_ready_q;
  assign row_w_en   = {ROWS{beat}};
  assign col_w_en   = {COLS{beat}};
  // Command responses land in the same cycle as the start strobe.
  assign pe_clr     = (state_q == ST_IDLE) && start && k_ok;
  assign err        = ((state_q == ST_IDLE) && start && !k_ok) || abort_err;
  assign busy       = busy_st;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - self-checking bench for systolic_array_ctrl

module tb_systolic_array_ctrl;

  localparam int ROWS      = 3;
  localparam int COLS      = 3;
  localparam int DEPTH     = 8;
  localparam int KW        = 4;
  localparam int DRAIN_CYC = ROWS + COLS - 1;
  localparam int MAXRC     = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            load_valid;
  logic            load_ready;
  logic [ROWS-1:0] row_w_en;
  logic [COLS-1:0] col_w_en;
  logic [ROWS-1:0] row_r_en;
  logic [COLS-1:0] col_r_en;
  logic            pe_clr;
  logic            busy;
  logic            done;
  logic            err;
`ifdef SA_CTRL_ABORT_EN
  logic            abort;
`endif

  always #5 clk = ~clk;

  systolic_array_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .KW(KW), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
`ifdef SA_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .k_len      (k_len),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .row_w_en   (row_w_en),
    .col_w_en   (col_w_en),
    .row_r_en   (row_r_en),
    .col_r_en   (col_r_en),
    .pe_clr     (pe_clr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic       start;
    logic [3:0] k;
    logic       lv;
    logic       ab;
  } stim_t;

  // {load_ready, row_w_en, col_w_en, row_r_en, col_r_en, pe_clr, busy, done, err}
  typedef logic [16:0] exp_t;

  typedef struct {
    int k;
    int mode;   // 0: load_valid held, 1: toggling 1,0,1.., 2: random
    bit noise;  // random start/k_len strobes while the pass is running
  } vec_t;

  int    checks   = 0;
  int    failures = 0;
  int    pass_id  = 0;
  stim_t sq[$];
  exp_t  eq[$];

  function automatic exp_t mk(logic lr, logic w, logic [2:0] rr, logic [2:0] cr,
                              logic pe, logic bz, logic dn, logic er);
    return {lr, {3{w}}, {3{w}}, rr, cr, pe, bz, dn, er};
  endfunction

  function automatic logic [2:0] skew(int t, int k, int n);
    logic [2:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = (t >= i) && (t < i + k);
    return v;
  endfunction

  function automatic stim_t noisy(bit noise, logic lv);
    stim_t s;
    s.start = noise ? 1'($urandom % 2) : 1'b0;
    s.k     = 4'($urandom);
    s.lv    = lv;
    s.ab    = 1'b0;
    return s;
  endfunction

  // Expected cycle-by-cycle trace of one pass, derived from the phase lengths.
  task automatic build(int k, int mode, bit noise, int abort_t);
    stim_t s;
    bit    legal   = (k >= 1) && (k <= DEPTH);
    bit    aborted = 0;
    int    beats   = 0;
    int    c       = 0;
    logic  lv;
    s.start = 1'b1; s.k = k[3:0]; s.lv = 1'b0; s.ab = 1'b0;
    sq.push_back(s);
    eq.push_back(legal ? mk(0, 0, 0, 0, 1, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 1));
    if (legal) begin
      while (beats < k) begin
        lv = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((c % 2) == 0) : 1'($urandom % 2);
        sq.push_back(noisy(noise, lv));
        eq.push_back(mk(1, lv, 0, 0, 0, 1, 0, 0));
        beats += int'(lv);
        c++;
      end
      for (int t = 0; t < k + MAXRC - 1; t++) begin
        s = noisy(noise, 1'b0);
        if (t == abort_t) s.ab = 1'b1;
        sq.push_back(s);
        eq.push_back(mk(0, 0, skew(t, k, ROWS), skew(t, k, COLS), 0, 1, 0, 0));
        if (t == abort_t) begin
          aborted = 1;
          break;
        end
      end
      if (aborted) begin
        s = '0;
        sq.push_back(s);
        eq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
      end else begin
        for (int d = 0; d < DRAIN_CYC; d++) begin
          sq.push_back(noisy(noise, 1'b0));
          eq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
        end
        sq.push_back(noisy(noise, 1'b0));
        eq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
      end
    end
    s = '0;
    sq.push_back(s);
    eq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic exp_t outs();
    return {load_ready, row_w_en, col_w_en, row_r_en, col_r_en, pe_clr, busy, done, err};
  endfunction

  task automatic check(string name, int cyc, exp_t act, exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s pass=%0d cyc=%0d got=%05h exp=%05h", name, pass_id, cyc, act, exp);
    end
  endtask

  // Applies the first n queued cycles (all when n < 0) and checks each one.
  task automatic play(int n);
    int lim = (n < 0 || n > sq.size()) ? sq.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      start      = sq[i].start;
      k_len      = sq[i].k;
      load_valid = sq[i].lv;
`ifdef SA_CTRL_ABORT_EN
      abort      = sq[i].ab;
`endif
      @(negedge clk);
      check("trace", i, outs(), eq[i]);
    end
    sq.delete();
    eq.delete();
    pass_id++;
  endtask

  vec_t vecs[8];

  initial begin
    vecs = '{'{3, 0, 0}, '{0, 0, 0}, '{9, 0, 0}, '{4, 1, 0},
             '{3, 0, 1}, '{8, 2, 1}, '{1, 0, 0}, '{15, 1, 0}};

    rstn = 1'b0; start = 1'b0; k_len = '0; load_valid = 1'b0;
`ifdef SA_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("reset", 0, outs(), '0);
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int v = 0; v < 8; v++) begin
      build(vecs[v].k, vecs[v].mode, vecs[v].noise, -1);
      play(-1);
    end

    // Reset in the STREAM t=2 cycle: start + 3 beats + t=0..2.
    build(3, 0, 0, -1);
    play(1 + 3 + 3);
    #1 rstn = 1'b0;
    #1 check("mid_reset", 0, outs(), '0);
    start = 1'b0; load_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    build(1, 0, 0, -1);
    play(-1);

`ifdef SA_CTRL_ABORT_EN
    build(3, 0, 0, 1);
    play(-1);
    build(2, 0, 0, -1);
    play(-1);
`endif

    for (int r = 0; r < 25; r++) begin
      build(int'($urandom_range(0, 10)), 2, 1'($urandom % 2), -1);
      play(-1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
